configurable_2mode_deserializer: RTL
====================================

Name: configurable_2mode_deserializer

Overview:
Serial-to-parallel receiver for the 1-lane/2-lane serial link used by our configurable-mode bit counters.
- Samples 1 bit per cycle (single-lane modes) or 2 bits per cycle (dual-lane mode), MSB first.
- Assembles a FRAME_SIZE-bit frame and presents it with a valid/ready handshake.
- Sits between the serial pad-side logic and the parallel consumer, e.g. a CSR or FIFO write port.

Parameters:
FRAME_SIZE, 40, bits per frame; any value >= 2, odd values allowed.
CNT_WIDTH, 6, bit-counter width; must satisfy 2^CNT_WIDTH > FRAME_SIZE.

Ports:
clk  input  1  Clock, rising edge.
rst_n  input  1  Reset, asynchronous assert, active-low.
mode_i  input  2  00 = off; 01 = single lane on sd_i[0]; 10 = single lane on sd_i[1]; 11 = dual lane.
start_i  input  1  Frame start strobe, 1 cycle; first data sampled on the following cycle.
sd_i  input  2  Serial data. In dual mode sd_i[1] is the earlier (more significant) bit.
frame_rdy_i  input  1  Consumer ready.
frame_o  output  FRAME_SIZE  Assembled frame, MSB = first received bit.
frame_vld_o  output  1  Frame valid.
busy_o  output  1  High in RECV or HOLD.
cnt_o  output  CNT_WIDTH  Bits received so far in the current frame.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; shift register, cnt_o, frame_o and latched mode cleared to 0.
  - frame_vld_o = 0, busy_o = 0.
  - Reset mid-frame discards the partial frame. No vld pulse is produced after reset release.
- States: IDLE, RECV, HOLD. State is encoded in 2 bits; the unused encoding goes to IDLE.
- IDLE:
  - start_i = 1 with mode_i != 00: latch mode_i into mode_q, clear cnt, go to RECV.
  - start_i with mode_i = 00 is ignored.
- RECV: each cycle, shift data into the LSB end according to mode_q.
  - 01: shift in sd_i[0]; cnt += 1.
  - 10: shift in sd_i[1]; cnt += 1.
  - 11: shift in {sd_i[1], sd_i[0]}; cnt += 2.
  - Precise end: single mode with cnt == FRAME_SIZE-1, or dual mode with cnt == FRAME_SIZE-2. Shift the normal amount and go to HOLD.
  - Overflow end (dual mode, cnt == FRAME_SIZE-1, odd FRAME_SIZE only): shift in sd_i[1] only; sd_i[0] is dropped. Go to HOLD.
  - On the transition to HOLD: frame_o <= completed shift value, frame_vld_o <= 1, cnt resets to 0.
  - mode_i and start_i are ignored in RECV; the mode is fixed for the whole frame.
- Latency: frame_vld_o rises on the clock edge after the last sample.
  - FRAME_SIZE = 40: start at cycle 0, samples at cycles 1..40, vld high from cycle 41.
  - Dual mode: 20 samples (cycles 1..20), vld high from cycle 21.
- HOLD:
  - frame_o and frame_vld_o stay stable until frame_vld_o & frame_rdy_i.
  - On that handshake, frame_vld_o drops next cycle. If start_i & (mode_i != 00) in the same cycle, go directly to RECV with the new mode (back-to-back frames, no idle gap). Otherwise go to IDLE.
  - start_i in HOLD without the handshake is ignored; no overflow buffering.
- frame_o holds the last frame after the handshake; it is updated only on a HOLD entry.
- busy_o = (state != IDLE), decoded combinationally from the state register.
- cnt_o is a direct register output. Arithmetic is CNT_WIDTH-bit and never wraps, given the parameter constraint.

Decomposition:
- Shared package (deser_pkg):
  - Mode localparams MODE_OFF = 2'b00, MODE_SL0 = 2'b01, MODE_SL1 = 2'b10, MODE_DL = 2'b11.
  - State encoding constants for IDLE, RECV, HOLD.
- One natural sub-module, deser_bit_counter: async-reset counter with +1/+2 step, precise-end and overflow-end outputs, and a clear input.
- The shift register and FSM stay in the top module.

Test Plan:
- Single lane, FRAME_SIZE = 40, mode 01, stream 40'hA5_1234_5678 MSB first on sd_i[0], frame_rdy_i = 1 -> frame_o = 40'hA512345678, frame_vld_o high exactly cycle 41 for 1 cycle, cnt_o counts 1..39 then 0.
- Dual lane, mode 11, same frame as bit pairs -> vld at cycle 21, frame_o = 40'hA512345678. Repeat with mode 10 on sd_i[1] -> vld at cycle 41, same value.
- FRAME_SIZE = 41, mode 11, data 41'h1_5555_5555_55 -> 21 beats, last beat takes sd_i[1] only (sd_i[0] driven 1, must not appear), vld at cycle 22 with the exact value.
- Backpressure: frame_rdy_i = 0 for 5 cycles after vld, start_i pulsed during HOLD -> frame_o/vld stable, start ignored. Then rdy = 1 together with start_i, mode 01 -> next frame received with no gap.
- Reset mid-frame: rst_n low asynchronously at cnt_o = 17 -> outputs zero immediately without a clock edge. After release: IDLE, no vld. start_i with mode_i = 00 -> stays IDLE, busy_o = 0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared definitions for the configurable 1-lane/2-lane serial frame receiver:
// lane-mode codes, FSM state encoding and a small mode decode helper.
package deser_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_SL0 = 2'b01;
    localparam logic [1:0] MODE_SL1 = 2'b10;
    localparam logic [1:0] MODE_DL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic logic is_dual(input logic [1:0] mode);
        return (mode == MODE_DL);
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for one frame: steps by 1 or 2, flags the last beat of a frame
// and returns to zero on its own when that beat is consumed.
module deser_bit_counter
    import deser_pkg::*;
#(
    parameter int FRAME_SIZE = 40,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 dual,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 precise_end,
    output logic                 overflow_end
);

    localparam logic [CNT_WIDTH-1:0] LAST_SINGLE = CNT_WIDTH'(FRAME_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_DUAL   = CNT_WIDTH'(FRAME_SIZE - 2);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] step_s;

    // End-of-frame decode; overflow_end is only reachable with an odd frame size.
    always_comb begin
        step_s       = dual ? CNT_WIDTH'(2) : CNT_WIDTH'(1);
        precise_end  = dual ? (cnt_r == LAST_DUAL) : (cnt_r == LAST_SINGLE);
        overflow_end = dual && (cnt_r == LAST_SINGLE);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (precise_end || overflow_end) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + step_s;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/configurable_2mode_deserializer.sv
// Serial-to-parallel frame receiver, 1 or 2 bits per cycle MSB first,
// presenting each completed frame through a valid/ready handshake.
module configurable_2mode_deserializer
    import deser_pkg::*;
#(
    parameter int FRAME_SIZE = 40,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode_i,
    input  logic                  start_i,
    input  logic [1:0]            sd_i,
    input  logic                  frame_rdy_i,
    output logic [FRAME_SIZE-1:0] frame_o,
    output logic                  frame_vld_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    state_t                state_r;
    logic [1:0]            mode_r;
    logic [FRAME_SIZE-1:0] shift_r;
    logic [FRAME_SIZE-1:0] frame_r;
    logic                  vld_r;

    logic                  start_ok_s;
    logic                  handshake_s;
    logic                  dual_s;
    logic                  lane_bit_s;
    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic                  precise_end_s;
    logic                  overflow_end_s;
    logic                  end_s;
    logic [FRAME_SIZE+1:0] wide_dual_s;
    logic [FRAME_SIZE:0]   wide_one_s;
    logic [FRAME_SIZE-1:0] shift_next_s;

    // Control decode and next shift value; the overflow beat reuses the single-bit path on sd_i[1].
    always_comb begin
        start_ok_s   = start_i && (mode_i != MODE_OFF);
        handshake_s  = vld_r && frame_rdy_i;
        dual_s       = is_dual(mode_r);
        lane_bit_s   = (mode_r == MODE_SL0) ? sd_i[0] : sd_i[1];
        cnt_en_s     = (state_r == ST_RECV);
        cnt_clr_s    = start_ok_s && (state_r != ST_RECV);
        end_s        = precise_end_s || overflow_end_s;
        wide_dual_s  = {shift_r, sd_i};
        wide_one_s   = {shift_r, lane_bit_s};
        shift_next_s = (dual_s && !overflow_end_s) ? wide_dual_s[FRAME_SIZE-1:0]
                                                   : wide_one_s[FRAME_SIZE-1:0];
    end

    deser_bit_counter #(
        .FRAME_SIZE (FRAME_SIZE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_bit_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (cnt_clr_s),
        .en           (cnt_en_s),
        .dual         (dual_s),
        .cnt          (cnt_o),
        .precise_end  (precise_end_s),
        .overflow_end (overflow_end_s)
    );

    // Receive FSM with shift register and registered frame/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_OFF;
            shift_r <= '0;
            frame_r <= '0;
            vld_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        mode_r  <= mode_i;
                        state_r <= ST_RECV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    shift_r <= shift_next_s;
                    if (end_s) begin
                        frame_r <= shift_next_s;
                        vld_r   <= 1'b1;
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_HOLD: begin
                    if (handshake_s) begin
                        vld_r <= 1'b0;
                        if (start_ok_s) begin
                            mode_r  <= mode_i;
                            state_r <= ST_RECV;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    vld_r   <= 1'b0;
                end
            endcase
        end
    end

    assign frame_o     = frame_r;
    assign frame_vld_o = vld_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule
